microcode_sequencer: RTL and testbench
======================================

// Module: microcode_sequencer
// PURPOSE
//  Parametrised microcoded sequencer: next generation of the control unit. Forms micro-address {step, opcode, flags}
//  and reads a writable microcode store. Drives a registered control-word payload to datapath/registers/ALU.
//  Adds a memory-wait stall handshake, halt/start control, a run-time programming port and single-edge timing.
// PARAMETERS
//  STEP_W    4   step counter width (steps per macro-instruction = 2**STEP_W)
//  OPCODE_W  8   macro-instruction opcode width, loaded from bus
//  FLAG_W    1   ALU flag inputs folded into micro-address
//  CW_W      32  control-word width; bits [3:0] sequencer-owned, [CW_W-1:4] payload
//  ADDR_W    STEP_W+OPCODE_W+FLAG_W (derived, localparam)
// PORTS
//  clock       in   1         system clock, all state on posedge
//  reset       in   1         synchronous, active-high
//  start       in   1         leave HALTED, begin at step 0
//  mem_ready   in   1         memory handshake, 1 = current access complete
//  alu_flag    in   FLAG_W    ALU flags, sampled combinationally into address
//  bus         in   OPCODE_W  opcode source for load
//  prog_we     in   1         microcode write strobe
//  prog_addr   in   ADDR_W    microcode write address
//  prog_data   in   CW_W      microcode write data
//  ctrl_out    out  CW_W-4    registered control payload to datapath
//  halted      out  1         1 in HALTED (and FAULT)
//  step        out  STEP_W    current step, debug
//  fault       out  1         step-limit fault (SEQ_STEP_LIMIT_EN only, else tied 0)
// BEHAVIOUR
//  - CW sequencer bits: [0] next_instr, [1] load, [2] halt, [3] wait_mem. cw = store[{step,opcode,alu_flag}].
//  - Reset: state=HALTED, step=0, opcode=0, ctrl_out=0, halted=1, fault=0. Store contents NOT cleared.
//  - States: HALTED, RUN, STALL (+FAULT with option).
//  - HALTED: ctrl_out=0; start=1 -> RUN, step=0 next cycle. Other inputs ignored except prog_we.
//  - RUN, each posedge: ctrl_out<=cw[CW_W-1:4]; if load, opcode<=bus.
//    halt=1 -> HALTED, step<=0 (halt wins over next_instr and wait_mem; load still takes effect).
//    else wait_mem=1 & mem_ready=0 -> STALL, step held.
//    else next_instr=1 -> step<=0; else step<=step+1.
//  - STALL: ctrl_out, step, opcode held; no store read used. mem_ready=1 -> RUN;
//    step advances per held word's next_instr (0 or step+1) in the same edge.
//  - Latency: cw for address A appears on ctrl_out one cycle after A is presented.
//  - Step wrap: step at 2**STEP_W-1 without next_instr wraps to 0 (no option) or faults (option).
//  - start while RUN/STALL ignored. Reset in any state (incl. mid-stall) -> reset values next cycle.
//  - prog_we writes store on posedge in any state; a write to the address read this cycle is seen next cycle.
// CONFIGURATION
//  SEQ_STEP_LIMIT_EN defined: wrap in RUN -> FAULT: ctrl_out=0, fault=1, halted=1, only reset exits.
//  Undefined: step wraps silently; fault output tied 0; no FAULT state.
// STRUCTURE
//  Package control: CW_NEXT_INSTR/CW_LOAD/CW_HALT/CW_WAIT_MEM bit indices, CW_SEQ_BITS=4,
//   typedef enum seq_state_e {SEQ_HALTED, SEQ_RUN, SEQ_STALL, SEQ_FAULT}.
//  Sub-module microcode_store: 2**ADDR_W x CW_W, 1 sync write port, 1 async read port, no reset.
//  Top: FSM, step counter, opcode register, ctrl_out register.
// TESTING
//  1 Reset, program opcode 0x00 steps 0..2 payloads 0x11/0x22/0x33 with next_instr at step 2, start
//    -> ctrl_out 0x11,0x22,0x33,0x11 on consecutive cycles; step 0,1,2,0.
//  2 Step 0 load=1 with bus=0x5A -> step 1 reads opcode 0x5A's word; alu_flag 0 vs 1 selects distinct words.
//  3 wait_mem word, mem_ready low 3 cycles -> ctrl_out/step frozen 3 cycles, advance on cycle mem_ready=1.
//  4 Word with halt=1 and next_instr=1 -> halted=1, ctrl_out=0, step=0; start pulse resumes at step 0.
//  5 Reset asserted during STALL -> halted=1, ctrl_out=0, opcode=0 next cycle; store contents preserved.
//  6 All 16 steps without next_instr: no option -> step wraps 15->0; with SEQ_STEP_LIMIT_EN -> fault=1, start ignored.

Source files
------------

// File: rtl/microcode_sequencer_pkg.sv
// rtl/microcode_sequencer_pkg.sv - sequencer-owned control-word bit indices and FSM state encoding
package microcode_sequencer_pkg;

  localparam int CW_NEXT_INSTR = 0;
  localparam int CW_LOAD       = 1;
  localparam int CW_HALT       = 2;
  localparam int CW_WAIT_MEM   = 3;
  localparam int CW_SEQ_BITS   = 4;

  typedef enum logic [1:0] {
    SEQ_HALTED = 2'd0,
    SEQ_RUN    = 2'd1,
    SEQ_STALL  = 2'd2,
    SEQ_FAULT  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/microcode_store.sv
// rtl/microcode_store.sv - writable microcode store, one sync write port, one async read port, no reset
module microcode_store #(
  parameter int ADDR_W = 13,
  parameter int CW_W   = 32
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [CW_W-1:0]   wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [CW_W-1:0]   rdata
);

  logic [CW_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/microcode_sequencer.sv
// rtl/microcode_sequencer.sv - microcoded sequencer: FSM, step counter, opcode and control-payload registers
// SEQ_STEP_LIMIT_EN: step overflow without next_instr enters a sticky FAULT state instead of wrapping.
module microcode_sequencer
  import microcode_sequencer_pkg::*;
#(
  parameter int STEP_W   = 4,
  parameter int OPCODE_W = 8,
  parameter int FLAG_W   = 1,
  parameter int CW_W     = 32,
  localparam int ADDR_W  = STEP_W + OPCODE_W + FLAG_W
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   mem_ready,
  input  logic [FLAG_W-1:0]      alu_flag,
  input  logic [OPCODE_W-1:0]    bus,
  input  logic                   prog_we,
  input  logic [ADDR_W-1:0]      prog_addr,
  input  logic [CW_W-1:0]        prog_data,
  output logic [CW_W-5:0]        ctrl_out,
  output logic                   halted,
  output logic [STEP_W-1:0]      step,
  output logic                   fault
);

  seq_state_e                    state_q, state_d;
  logic [STEP_W-1:0]             step_q, step_d;
  logic [OPCODE_W-1:0]           opcode_q, opcode_d;
  logic [CW_W-CW_SEQ_BITS-1:0]   ctrl_q, ctrl_d;
  logic                          held_next_q, held_next_d;
  logic                          halted_q, halted_d;
  logic                          fault_q, fault_d;
  logic [CW_W-1:0]               cw;
  logic                          do_adv;
  logic                          adv_next;

  microcode_store #(
    .ADDR_W (ADDR_W),
    .CW_W   (CW_W)
  ) u_store (
    .clock (clock),
    .we    (prog_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr ({step_q, opcode_q, alu_flag}),
    .rdata (cw)
  );

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    opcode_d    = opcode_q;
    ctrl_d      = ctrl_q;
    held_next_d = held_next_q;
    do_adv      = 1'b0;
    adv_next    = 1'b0;

    unique case (state_q)
      SEQ_HALTED: begin
        ctrl_d = '0;
        step_d = '0;
        if (start) begin
          state_d = SEQ_RUN;
        end
      end
      SEQ_RUN: begin
        ctrl_d      = cw[CW_W-1:CW_SEQ_BITS];
        held_next_d = cw[CW_NEXT_INSTR];
        if (cw[CW_LOAD]) begin
          opcode_d = bus;
        end
        if (cw[CW_HALT]) begin
          state_d = SEQ_HALTED;
          step_d  = '0;
          ctrl_d  = '0;
        end else if (cw[CW_WAIT_MEM] && !mem_ready) begin
          state_d = SEQ_STALL;
        end else begin
          do_adv   = 1'b1;
          adv_next = cw[CW_NEXT_INSTR];
        end
      end
      SEQ_STALL: begin
        // The stalled word's next_instr was captured on entry; the store is not re-read here.
        if (mem_ready) begin
          state_d  = SEQ_RUN;
          do_adv   = 1'b1;
          adv_next = held_next_q;
        end
      end
      default: begin
        ctrl_d = '0;
      end
    endcase

    if (do_adv) begin
      if (adv_next) begin
        step_d = '0;
      end else begin
`ifdef SEQ_STEP_LIMIT_EN
        if (&step_q) begin
          state_d = SEQ_FAULT;
          ctrl_d  = '0;
        end else begin
          step_d = step_q + STEP_W'(1);
        end
`else
        step_d = step_q + STEP_W'(1);
`endif
      end
    end

    halted_d = (state_d == SEQ_HALTED) || (state_d == SEQ_FAULT);
    fault_d  = (state_d == SEQ_FAULT);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= SEQ_HALTED;
      step_q      <= '0;
      opcode_q    <= '0;
      ctrl_q      <= '0;
      held_next_q <= 1'b0;
      halted_q    <= 1'b1;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      opcode_q    <= opcode_d;
      ctrl_q      <= ctrl_d;
      held_next_q <= held_next_d;
      halted_q    <= halted_d;
      fault_q     <= fault_d;
    end
  end

  assign ctrl_out = ctrl_q;
  assign halted   = halted_q;
  assign step     = step_q;
`ifdef SEQ_STEP_LIMIT_EN
  assign fault    = fault_q;
`else
  assign fault    = 1'b0;
`endif

endmodule

// File: tb/tb_microcode_sequencer.sv
// tb/tb_microcode_sequencer.sv - directed self-checking bench for microcode_sequencer
module tb_microcode_sequencer;

  localparam logic [3:0] NX = 4'b0001;
  localparam logic [3:0] LD = 4'b0010;
  localparam logic [3:0] HL = 4'b0100;
  localparam logic [3:0] WM = 4'b1000;

  logic        clock = 1'b0;
  logic        reset, start, mem_ready, prog_we;
  logic [0:0]  alu_flag;
  logic [7:0]  bus;
  logic [12:0] prog_addr;
  logic [31:0] prog_data;
  logic [27:0] ctrl_out;
  logic        halted, fault;
  logic [3:0]  step;

  int total = 0;
  int bad   = 0;

  microcode_sequencer dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .mem_ready (mem_ready),
    .alu_flag  (alu_flag),
    .bus       (bus),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .ctrl_out  (ctrl_out),
    .halted    (halted),
    .step      (step),
    .fault     (fault)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [12:0] addr(input logic [3:0] s, input logic [7:0] op, input logic f);
    return {s, op, f};
  endfunction

  task automatic prog(input logic [12:0] a, input logic [27:0] pay, input logic [3:0] seq);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = {pay, seq};
    tick();
    prog_we   = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Reset, start on opcode 0 with flag 1 so the step-0 word loads bus; ends at step 1 of opcode v.
  task automatic launch(input logic [7:0] v);
    do_reset();
    alu_flag  = 1'b1;
    bus       = v;
    mem_ready = 1'b1;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mem_ready = 1'b1; prog_we = 1'b0;
    alu_flag = 1'b0; bus = 8'h00; prog_addr = '0; prog_data = '0;
    tick();
    reset = 1'b0;
    check("rst_halted", {31'd0, halted}, 32'd1);
    check("rst_ctrl", {4'd0, ctrl_out}, 32'd0);
    check("rst_step", {28'd0, step}, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);

    prog(addr(4'd0, 8'h00, 1'b0), 28'h11, 4'b0);
    prog(addr(4'd1, 8'h00, 1'b0), 28'h22, 4'b0);
    prog(addr(4'd2, 8'h00, 1'b0), 28'h33, NX);
    prog(addr(4'd0, 8'h00, 1'b1), 28'h40, LD);
    prog(addr(4'd1, 8'h5A, 1'b0), 28'h50, NX);
    prog(addr(4'd1, 8'h5A, 1'b1), 28'h51, NX);
    prog(addr(4'd1, 8'h33, 1'b0), 28'h70, WM);
    prog(addr(4'd2, 8'h33, 1'b0), 28'h71, NX);
    prog(addr(4'd1, 8'h44, 1'b0), 28'h80, HL | NX | WM);
    prog(addr(4'd0, 8'h44, 1'b0), 28'h90, NX);
    for (int s = 1; s < 16; s++) prog(addr(4'(s), 8'h66, 1'b0), 28'hA0 + 28'(s), 4'b0);
    prog(addr(4'd0, 8'h66, 1'b0), 28'hB0, HL);
    check("halted_while_prog", {31'd0, halted}, 32'd1);

    // basic three-step instruction loops back to step 0
    alu_flag = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t1_start_halted", {31'd0, halted}, 32'd0);
    check("t1_start_step", {28'd0, step}, 32'd0);
    check("t1_start_ctrl", {4'd0, ctrl_out}, 32'd0);
    tick(); check("t1_c0", {4'd0, ctrl_out}, 32'h11); check("t1_s0", {28'd0, step}, 32'd1);
    tick(); check("t1_c1", {4'd0, ctrl_out}, 32'h22); check("t1_s1", {28'd0, step}, 32'd2);
    tick(); check("t1_c2", {4'd0, ctrl_out}, 32'h33); check("t1_s2", {28'd0, step}, 32'd0);
    tick(); check("t1_c3", {4'd0, ctrl_out}, 32'h11); check("t1_s3", {28'd0, step}, 32'd1);

    // opcode load and flag-selected words
    launch(8'h5A);
    check("t2_load_ctrl", {4'd0, ctrl_out}, 32'h40);
    check("t2_load_step", {28'd0, step}, 32'd1);
    tick();
    check("t2_flag1", {4'd0, ctrl_out}, 32'h51);
    check("t2_flag1_step", {28'd0, step}, 32'd0);
    launch(8'h5A);
    alu_flag = 1'b0;
    tick();
    check("t2_flag0", {4'd0, ctrl_out}, 32'h50);

    // memory-wait stall for three low cycles
    launch(8'h33);
    alu_flag  = 1'b0;
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_stall_ctrl", {4'd0, ctrl_out}, 32'h70);
      check("t3_stall_step", {28'd0, step}, 32'd1);
    end
    mem_ready = 1'b1;
    tick();
    check("t3_release_step", {28'd0, step}, 32'd2);
    check("t3_release_ctrl", {4'd0, ctrl_out}, 32'h70);
    tick();
    check("t3_next_ctrl", {4'd0, ctrl_out}, 32'h71);
    check("t3_next_step", {28'd0, step}, 32'd0);

    // reset in the middle of a stall
    launch(8'h33);
    alu_flag  = 1'b0;
    mem_ready = 1'b0;
    tick();
    check("t5_in_stall", {4'd0, ctrl_out}, 32'h70);
    do_reset();
    check("t5_halted", {31'd0, halted}, 32'd1);
    check("t5_ctrl", {4'd0, ctrl_out}, 32'd0);
    check("t5_step", {28'd0, step}, 32'd0);
    mem_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("t5_opcode0_store_kept", {4'd0, ctrl_out}, 32'h11);

    // halt beats next_instr and wait_mem; start resumes at step 0
    launch(8'h44);
    alu_flag  = 1'b0;
    mem_ready = 1'b0;
    tick();
    check("t4_halted", {31'd0, halted}, 32'd1);
    check("t4_ctrl", {4'd0, ctrl_out}, 32'd0);
    check("t4_step", {28'd0, step}, 32'd0);
    mem_ready = 1'b1;
    tick();
    check("t4_stays_halted", {31'd0, halted}, 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t4_resume_halted", {31'd0, halted}, 32'd0);
    check("t4_resume_step", {28'd0, step}, 32'd0);
    tick();
    check("t4_resume_ctrl", {4'd0, ctrl_out}, 32'h90);

    // sixteen steps without next_instr
    launch(8'h66);
    alu_flag = 1'b0;
    for (int s = 1; s < 15; s++) begin
      tick();
      check("t6_walk_ctrl", {4'd0, ctrl_out}, 32'hA0 + 32'(s));
      check("t6_walk_step", {28'd0, step}, 32'(s + 1));
    end
    tick();
`ifdef SEQ_STEP_LIMIT_EN
    check("t6_fault", {31'd0, fault}, 32'd1);
    check("t6_fault_halted", {31'd0, halted}, 32'd1);
    check("t6_fault_ctrl", {4'd0, ctrl_out}, 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("t6_start_ignored", {31'd0, fault}, 32'd1);
    check("t6_start_ignored_ctrl", {4'd0, ctrl_out}, 32'd0);
`else
    check("t6_wrap_ctrl", {4'd0, ctrl_out}, 32'hAF);
    check("t6_wrap_step", {28'd0, step}, 32'd0);
    check("t6_no_fault", {31'd0, fault}, 32'd0);
    tick();
    check("t6_wrap_halt", {31'd0, halted}, 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
